// File: rtl/cntr_share_ctrl.sv
// rtl/cntr_share_ctrl.sv - round-robin shared up-counter controller (optional CNTR_REQ_DROP_EN: abort run on dropped request)
module cntr_share_ctrl #(
    parameter int CNT_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [3:0]         req,
    input  logic [4*CNT_W-1:0] tc_in,
    output logic [3:0]         gnt,
    output logic [CNT_W-1:0]   q,
    output logic               busy,
    output logic               done,
    output logic [1:0]         done_id
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [1:0]         ptr, ptr_nxt;
    logic [1:0]         win, win_nxt;
    logic [1:0]         sel;
    logic               found;
    logic               drop;
    logic [CNT_W-1:0]   tc_r, tc_nxt;
    logic [CNT_W-1:0]   q_nxt;
    logic [3:0]         gnt_nxt;
    logic               done_nxt;
    logic [1:0]         done_id_nxt;

    // First active requester at or above ptr, wrapping 3 -> 0.
    always_comb begin
        sel   = ptr;
        found = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (!found && req[ptr + 2'(k)]) begin
                sel   = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end

`ifdef CNTR_REQ_DROP_EN
    assign drop = ~req[win];
`else
    assign drop = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        win_nxt     = win;
        tc_nxt      = tc_r;
        q_nxt       = q;
        gnt_nxt     = gnt;
        done_nxt    = 1'b0;
        done_id_nxt = done_id;
        case (state)
            IDLE: begin
                gnt_nxt = 4'b0000;
                q_nxt   = '0;
                if (found) begin
                    state_nxt = RUN;
                    win_nxt   = sel;
                    gnt_nxt   = 4'b0001 << sel;
                    tc_nxt    = tc_in[sel*CNT_W +: CNT_W];
                end
            end
            RUN: begin
                if (drop) begin
                    state_nxt = IDLE;
                    gnt_nxt   = 4'b0000;
                    q_nxt     = '0;
                    ptr_nxt   = win + 2'd1;
                end else if (q == tc_r) begin
                    state_nxt   = DONE;
                    done_nxt    = 1'b1;
                    done_id_nxt = win;
                end else begin
                    q_nxt = q + CNT_W'(1);
                end
            end
            DONE: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                q_nxt     = '0;
                ptr_nxt   = win + 2'd1;
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 4'b0000;
                q_nxt     = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= 2'd0;
            win     <= 2'd0;
            tc_r    <= '0;
            q       <= '0;
            gnt     <= 4'b0000;
            busy    <= 1'b0;
            done    <= 1'b0;
            done_id <= 2'd0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            win     <= win_nxt;
            tc_r    <= tc_nxt;
            q       <= q_nxt;
            gnt     <= gnt_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= done_nxt;
            done_id <= done_id_nxt;
        end
    end

endmodule

// File: tb/tb_cntr_share_ctrl.sv
// tb/tb_cntr_share_ctrl.sv - directed self-checking bench for cntr_share_ctrl
module tb_cntr_share_ctrl;

    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [3:0]     req;
    logic [4*W-1:0] tc_in;
    logic [3:0]     gnt;
    logic [W-1:0]   q;
    logic           busy;
    logic           done;
    logic [1:0]     done_id;

    int checks = 0;
    int errors = 0;

    cntr_share_ctrl #(.CNT_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .tc_in   (tc_in),
        .gnt     (gnt),
        .q       (q),
        .busy    (busy),
        .done    (done),
        .done_id (done_id)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".gnt"}, 32'(gnt), 32'h0);
        check({tag, ".q"}, 32'(q), 32'h0);
        check({tag, ".busy"}, 32'(busy), 32'h0);
        check({tag, ".done"}, 32'(done), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int order [5] = '{0, 1, 2, 3, 0};

        // Asynchronous reset before any clock edge
        rst = 1'b0; req = 4'b0000; tc_in = '0;
        #1;
        check_idle("rst0");
        check("rst0.done_id", 32'(done_id), 32'h0);
        #10;
        rst = 1'b1;

        // Single requester 1, tc=3
        tc_in[1*W +: W] = 4'd3;
        req = 4'b0010;
        tick();
        check("r1.gnt", 32'(gnt), 32'h2);
        check("r1.q0", 32'(q), 32'h0);
        check("r1.busy", 32'(busy), 32'h1);
        check("r1.done0", 32'(done), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("r1.q", 32'(q), 32'(i));
        end
        tick();
        check("r1.done", 32'(done), 32'h1);
        check("r1.done_id", 32'(done_id), 32'h1);
        check("r1.qhold", 32'(q), 32'h3);
        check("r1.gnt_done", 32'(gnt), 32'h2);
        req = 4'b0000;
        tick();
        check_idle("r1.idle");
        check("r1.id_hold", 32'(done_id), 32'h1);

        // Round robin with all requesting, tc=0
        rst = 1'b0; #2; rst = 1'b1;
        tc_in = '0;
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            tick();
            check("rr.gnt", 32'(gnt), 32'(4'b0001 << order[g]));
            check("rr.q", 32'(q), 32'h0);
            tick();
            check("rr.done", 32'(done), 32'h1);
            check("rr.done_id", 32'(done_id), 32'(order[g]));
            if (g == 4) req = 4'b0000;
            tick();
            check("rr.idle_gnt", 32'(gnt), 32'h0);
            check("rr.idle_busy", 32'(busy), 32'h0);
        end

        // Full-scale count, no wrap
        tc_in[0 +: W] = 4'd15;
        req = 4'b0001;
        tick();
        check("fs.gnt", 32'(gnt), 32'h1);
        check("fs.q0", 32'(q), 32'h0);
        for (int i = 1; i <= 15; i++) begin
            tick();
            check("fs.q", 32'(q), 32'(i));
        end
        tick();
        check("fs.done", 32'(done), 32'h1);
        check("fs.qhold", 32'(q), 32'hf);
        check("fs.done_id", 32'(done_id), 32'h0);
        req = 4'b0000;
        tick();
        check_idle("fs.idle");

        // Reset mid-run at q=5
        req = 4'b0001;
        tick();
        for (int i = 1; i <= 5; i++) tick();
        check("ab.q5", 32'(q), 32'h5);
        #2;
        rst = 1'b0;
        #1;
        check_idle("ab.async");
        check("ab.done_id", 32'(done_id), 32'h0);
        tick();
        check("ab.nodone", 32'(done), 32'h0);
        rst = 1'b1;
        tc_in[1*W +: W] = 4'd2;
        req = 4'b1010;
        tick();
        check("ab.gnt", 32'(gnt), 32'h2);
        check("ab.done_after", 32'(done), 32'h0);
        tick();
        tick();
        check("ab.q2", 32'(q), 32'h2);
        tick();
        check("ab.done", 32'(done), 32'h1);
        check("ab.done_id1", 32'(done_id), 32'h1);
        req = 4'b0000;
        tick();
        check_idle("ab.idle");

        // Request dropped mid-run by requester 2 at q=4
        rst = 1'b0; #2; rst = 1'b1;
        tc_in[2*W +: W] = 4'd10;
        req = 4'b0100;
        tick();
        check("dr.gnt", 32'(gnt), 32'h4);
        for (int i = 1; i <= 4; i++) tick();
        check("dr.q4", 32'(q), 32'h4);
        req = 4'b0000;
        tick();
`ifdef CNTR_REQ_DROP_EN
        check_idle("dr.abort");
`else
        check("dr.q5", 32'(q), 32'h5);
        check("dr.busy", 32'(busy), 32'h1);
        for (int i = 6; i <= 10; i++) begin
            tick();
            check("dr.q", 32'(q), 32'(i));
        end
        tick();
        check("dr.done", 32'(done), 32'h1);
        check("dr.done_id", 32'(done_id), 32'h2);
        check("dr.qhold", 32'(q), 32'ha);
        req = 4'b1111;
        tick();
        check_idle("dr.idle");
`endif
        req = 4'b1111;
        tick();
        check("dr.next_gnt", 32'(gnt), 32'h8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cntr_share_ctrl.md
CNTR_SHARE_CTRL -- requirements
Module: cntr_share_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 4, width of the shared up counter and of each terminal count.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  4  request lines, one per requester 0..3, level-sensitive.
REQ-005 SHALL have port tc_in  input  4*CNT_W  terminal counts; requester i uses bits [i*CNT_W +: CNT_W].
REQ-006 SHALL have port gnt  output  4  one-hot grant, all-zero when idle.
REQ-007 SHALL have port q  output  CNT_W  shared counter value.
REQ-008 SHALL have port busy  output  1  high in RUN or DONE.
REQ-009 SHALL have port done  output  1  one-cycle pulse on completion of a granted run.
REQ-010 SHALL have port done_id  output  2  index of the requester completing; valid while done=1, else holds last value.

Function
REQ-011 SHALL implement three states: IDLE, RUN, DONE; all outputs registered.
REQ-012 IDLE, req!=0 at an edge: SHALL select the winner round-robin, searching upward from pointer ptr with wrap 3->0, and at that edge enter RUN, set gnt to the winner, clear q to 0, and latch the winner's tc into tc_r.
REQ-013 IDLE, req==0: SHALL stay in IDLE; gnt=0, q=0.
REQ-014 RUN: SHALL increment q by 1 each cycle while q!=tc_r; when q==tc_r, SHALL enter DONE at the next edge with q held at tc_r.
REQ-015 Run length: q SHALL take values 0..tc_r, i.e. tc_r+1 cycles in RUN; tc_r=0 gives exactly one RUN cycle with q=0.
REQ-016 q SHALL never wrap; for tc_r = 2^CNT_W-1, q stops at all-ones.
REQ-017 DONE: SHALL last exactly one cycle with done=1, done_id=winner and gnt still asserted; next state SHALL be IDLE with gnt=0, q=0, and ptr=winner+1 mod 4.
REQ-018 SHALL spend at least one cycle in IDLE between successive grants; req changes during RUN/DONE SHALL not affect the current grant (subject to REQ-024).
REQ-019 tc_in changes after the grant edge SHALL not affect the run in progress.
REQ-020 A requester holding req continuously SHALL be re-granted only after every other active requester is served once (no starvation).

Reset
REQ-021 rst low SHALL immediately force state=IDLE, gnt=0, q=0, busy=0, done=0, done_id=0, ptr=0, tc_r=0, regardless of clk.
REQ-022 Reset asserted mid-RUN SHALL abort the run without a done pulse; after release, the first grant SHALL search from requester 0.
REQ-023 Release of rst SHALL take effect at the first rising clk edge with rst high.

Configuration
REQ-024 Macro CNTR_REQ_DROP_EN defined: in RUN, if req[winner]=0 at an edge, SHALL go directly to IDLE at that edge, with gnt=0, q=0, no done pulse, and ptr=winner+1 mod 4; in DONE a dropped req SHALL be ignored.
REQ-025 CNTR_REQ_DROP_EN undefined: a granted run SHALL always complete to DONE regardless of req.

Verification
REQ-026 Reset with rst=0, then req=4'b0010, tc for requester 1 = 3 -> gnt=0010; q=0,1,2,3 over 4 RUN cycles; then done=1 with done_id=1 for one cycle; then IDLE with gnt=0, q=0.
REQ-027 req=4'b1111 held, all tc=0 -> grant order 0,1,2,3,0; each grant gives 1 RUN cycle + 1 DONE cycle + 1 IDLE cycle.
REQ-028 req=4'b0001, tc0=15 -> q reaches 15, holds 15 in DONE, no wrap to 0, then done_id=0.
REQ-029 rst pulsed low between clk edges with q=5 in RUN -> outputs go to zero immediately; no done pulse; next grant from req=4'b1010 goes to 1.
REQ-030 Macro defined: requester 2 granted with tc2=10, req[2] dropped when q=4 -> IDLE at next edge, no done; next req=4'b1111 grants 3. Macro undefined: same stimulus -> run completes to q=10, done_id=2.
